// File: rtl/led_chase_pkg.sv
// Shared types and constants for the LED chase sequencer.
package led_chase_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_LOOP    = 2'd1,
    MODE_BOUNCE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] COL_G = 2'd0;
  localparam logic [1:0] COL_R = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/led_chase_prescaler.sv
// Step-rate divider: one-cycle tick every STEP_DIV enabled cycles; clr restarts the count.
module led_chase_prescaler
  import led_chase_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DW = cw(STEP_DIV);

  logic [DW-1:0] div_q, div_d;

  assign tick = en && (div_q == DW'(STEP_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (clr)     div_d = '0;
    else if (en) div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

endmodule

// File: rtl/led_chase_seq.sv
// Button-held LED chase across NUM_LED RGB LEDs with one-shot/loop/bounce modes.
// Define LED_CHASE_SYNC_EN to pass button_inp through a 2-flop synchroniser.
module led_chase_seq
  import led_chase_pkg::*;
#(
  parameter int NUM_LED   = 4,
  parameter int NUM_STEPS = 3 * NUM_LED,
  parameter int STEP_DIV  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button_inp,
  input  logic [1:0]                mode,
  output logic [NUM_LED-1:0]        led_r,
  output logic [NUM_LED-1:0]        led_g,
  output logic [NUM_LED-1:0]        led_b,
  output logic                      busy,
  output logic                      done,
  output logic [cw(NUM_STEPS)-1:0]  step_idx
);

  localparam int SW = cw(NUM_STEPS);
  localparam int LW = cw(NUM_LED);

  logic btn;

`ifdef LED_CHASE_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], button_inp};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end
  assign btn = sync_q[1];
`else
  assign btn = button_inp;
`endif

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [SW-1:0] step_q, step_d;
  logic [LW-1:0] led_q, led_d;
  logic [1:0]    col_q, col_d;
  logic          dir_q, dir_d;   // 0 = up, 1 = down
  logic          done_q, done_d;
  logic          tick, run_en;

  assign run_en = (state_q == ST_RUN) && btn;

  led_chase_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (!run_en),
    .tick (tick)
  );

  // led/colour move as a mixed-radix counter alongside step; no divide hardware.
  logic          led_top, led_bot;
  logic [LW-1:0] led_inc, led_dec;
  logic [1:0]    col_inc, col_dec;
  logic          at_last, at_first;

  assign led_top  = (led_q == LW'(NUM_LED - 1));
  assign led_bot  = (led_q == '0);
  assign led_inc  = led_top ? '0 : led_q + 1'b1;
  assign led_dec  = led_bot ? LW'(NUM_LED - 1) : led_q - 1'b1;
  assign col_inc  = !led_top ? col_q : (col_q == COL_B) ? COL_G : col_q + 1'b1;
  assign col_dec  = !led_bot ? col_q : (col_q == COL_G) ? COL_B : col_q - 1'b1;
  assign at_last  = (step_q == SW'(NUM_STEPS - 1));
  assign at_first = (step_q == '0);

  logic go_up, go_dn, clr_cnt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    step_d  = step_q;
    led_d   = led_q;
    col_d   = col_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    go_up   = 1'b0;
    go_dn   = 1'b0;
    clr_cnt = 1'b0;
    case (state_q)
      ST_IDLE: if (btn) begin
        state_d = ST_RUN;
        mode_d  = mode;
        clr_cnt = 1'b1;
      end
      ST_RUN: begin
        if (!btn) begin
          // Release beats any advance on the same cycle, including the final one.
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end else if (tick) begin
          if (mode_q == MODE_LOOP) begin
            if (at_last) begin clr_cnt = 1'b1; done_d = 1'b1; end
            else go_up = 1'b1;
          end else if (mode_q == MODE_BOUNCE) begin
            if (NUM_STEPS == 1) done_d = 1'b1;
            else if (!dir_q) begin
              if (at_last) begin dir_d = 1'b1; go_dn = 1'b1; end
              else go_up = 1'b1;
            end else begin
              if (at_first) begin dir_d = 1'b0; go_up = 1'b1; done_d = 1'b1; end
              else go_dn = 1'b1;
            end
          end else begin
            if (at_last) begin state_d = ST_HOLD; clr_cnt = 1'b1; done_d = 1'b1; end
            else go_up = 1'b1;
          end
        end
      end
      ST_HOLD: if (!btn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (clr_cnt) begin
      step_d = '0;
      led_d  = '0;
      col_d  = COL_G;
      dir_d  = 1'b0;
    end else if (go_up) begin
      step_d = step_q + 1'b1;
      led_d  = led_inc;
      col_d  = col_inc;
    end else if (go_dn) begin
      step_d = step_q - 1'b1;
      led_d  = led_dec;
      col_d  = col_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      step_q  <= '0;
      led_q   <= '0;
      col_q   <= COL_G;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      led_q   <= led_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    led_r = '0;
    led_g = '0;
    led_b = '0;
    if (state_q == ST_RUN) begin
      case (col_q)
        COL_G:   led_g[led_q] = 1'b1;
        COL_R:   led_r[led_q] = 1'b1;
        default: led_b[led_q] = 1'b1;
      endcase
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_led_chase_seq.sv
// Self-checking bench: two instances (12-step and 4-step) against a closed-form reference model.
module tb_led_chase_seq;

  localparam int SD = 2;
`ifdef LED_CHASE_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] step_a;
  logic [1:0] step_b;

  always #5 clk = ~clk;

  led_chase_seq #(.NUM_LED(4), .NUM_STEPS(12), .STEP_DIV(SD)) dut_a (
    .clk(clk), .rst(rst), .button_inp(button), .mode(mode),
    .led_r(r_a), .led_g(g_a), .led_b(b_a),
    .busy(busy_a), .done(done_a), .step_idx(step_a)
  );

  led_chase_seq #(.NUM_LED(4), .NUM_STEPS(4), .STEP_DIV(SD)) dut_b (
    .clk(clk), .rst(rst), .button_inp(button), .mode(mode),
    .led_r(r_b), .led_g(g_b), .led_b(b_b),
    .busy(busy_b), .done(done_b), .step_idx(step_b)
  );

  wire [21:0] obs_a = {r_a, g_a, b_a, busy_a, done_a, 4'b0, step_a};
  wire [21:0] obs_b = {r_b, g_b, b_b, busy_b, done_b, 6'b0, step_b};

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle / 1 run / 2 hold; k = cycles spent in RUN.
  int ns[2] = '{12, 4};
  int ph[2], k[2], md[2];
  bit dn[2];
  bit s1, s2;

  function automatic int f_step(int i);
    int n, p, per;
    n = k[i] / SD;
    if (md[i] == 1) return n % ns[i];
    if (md[i] == 2) begin
      if (ns[i] == 1) return 0;
      per = 2 * (ns[i] - 1);
      p = n % per;
      return (p < ns[i]) ? p : per - p;
    end
    return n;
  endfunction

  function automatic logic [21:0] exp_vec(int i);
    int st, li, ci;
    logic [3:0] r, g, b;
    r = '0; g = '0; b = '0; st = 0;
    if (ph[i] == 1) begin
      st = f_step(i);
      li = st % 4;
      ci = (st / 4) % 3;
      if (ci == 0)      g[li] = 1'b1;
      else if (ci == 1) r[li] = 1'b1;
      else              b[li] = 1'b1;
    end
    return {r, g, b, (ph[i] == 1), dn[i], 8'(st)};
  endfunction

  task automatic model_reset();
    s1 = 0; s2 = 0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; k[i] = 0; md[i] = 0; dn[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit be;
    int n;
    if (!rst) begin
      model_reset();
      return;
    end
    be = (SYNC_DLY != 0) ? s2 : button;
    s2 = s1;
    s1 = button;
    for (int i = 0; i < 2; i++) begin
      dn[i] = 0;
      case (ph[i])
        0: if (be) begin ph[i] = 1; k[i] = 0; md[i] = int'(mode); end
        1: begin
          if (!be) begin
            ph[i] = 0; k[i] = 0;
          end else begin
            k[i]++;
            if (k[i] % SD == 0) begin
              n = k[i] / SD;
              if (md[i] == 1) dn[i] = (n % ns[i] == 0);
              else if (md[i] == 2) begin
                if (ns[i] == 1) dn[i] = 1;
                else dn[i] = (n > 1) && (n % (2 * (ns[i] - 1)) == 1);
              end else if (n == ns[i]) begin
                ph[i] = 2; dn[i] = 1;
              end
            end
          end
        end
        default: if (!be) ph[i] = 0;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (obs_a !== 22'h0) begin errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 22'h0); end
    checks++;
    if (obs_b !== 22'h0) begin errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 22'h0); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL reset_idle_a: got %h expected %h", obs_a, exp_vec(0)); end
    end
  endtask

  task automatic test_oneshot();
    int pulses_a, pulses_b;
    pulses_a = 0; pulses_b = 0;
    mode = 2'd0;
    button = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      pulses_a += int'(done_a);
      pulses_b += int'(done_b);
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL oneshot_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      checks++;
      if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL oneshot_b cyc %0d: got %h expected %h", c, obs_b, exp_vec(1)); end
    end
    checks++;
    if (pulses_a != 1) begin errors++; $display("FAIL oneshot_done_count_a: got %0d expected 1", pulses_a); end
    checks++;
    if (pulses_b != 1) begin errors++; $display("FAIL oneshot_done_count_b: got %0d expected 1", pulses_b); end
    button = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL oneshot_release_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
    end
  endtask

  task automatic test_loop();
    mode = 2'd1;
    button = 1'b1;
    for (int c = 0; c < 56; c++) begin
      cyc();
      mode = 2'($urandom_range(0, 3));
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL loop_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      checks++;
      if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL loop_b cyc %0d: got %h expected %h", c, obs_b, exp_vec(1)); end
    end
    button = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
  endtask

  task automatic test_bounce();
    mode = 2'd2;
    button = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL bounce_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      checks++;
      if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL bounce_b cyc %0d: got %h expected %h", c, obs_b, exp_vec(1)); end
    end
    button = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL bounce_release_b cyc %0d: got %h expected %h", c, obs_b, exp_vec(1)); end
    end
  endtask

  task automatic test_release();
    bit hit;
    int dones;
    hit = 0;
    mode = 2'd0;
    button = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL release5_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      if (ph[0] == 1 && f_step(0) == 5) begin button = 1'b0; hit = 1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL release5_reach: got no step 5 expected step 5 within 40 cycles"); end
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL release5_after_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
    end

    // Release timed so the effective button drops on the last-step advance edge.
    hit = 0;
    dones = 0;
    button = 1'b0;
    mode = 2'd1;
    button = 1'b1;
    for (int c = 0; c < 60 && !hit; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL lasttick_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      if (ph[0] == 1 && k[0] == 2 * 12 - 1 - SYNC_DLY) begin button = 1'b0; hit = 1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL lasttick_reach: got no last step expected within 60 cycles"); end
    for (int c = 0; c < 5; c++) begin
      cyc();
      dones += int'(done_a);
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL lasttick_after_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL lasttick_no_done: got %0d pulses expected 0", dones); end
  endtask

  task automatic test_reset_midrun();
    mode = 2'd1;
    button = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL midrun_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_a !== 22'h0) begin errors++; $display("FAIL async_reset_a: got %h expected %h", obs_a, 22'h0); end
    checks++;
    if (obs_b !== 22'h0) begin errors++; $display("FAIL async_reset_b: got %h expected %h", obs_b, 22'h0); end
    button = 1'b0;
    cyc();
    checks++;
    if (obs_a !== 22'h0) begin errors++; $display("FAIL reset_held_a: got %h expected %h", obs_a, 22'h0); end
    rst = 1'b1;
    cyc();
    checks++;
    if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL reset_after_a: got %h expected %h", obs_a, exp_vec(0)); end
    checks++;
    if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL reset_after_b: got %h expected %h", obs_b, exp_vec(1)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 27) == 0) button = ~button;
      mode = 2'($urandom_range(0, 3));
      cyc();
      checks++;
      if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL random_a cyc %0d: got %h expected %h", c, obs_a, exp_vec(0)); end
      checks++;
      if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL random_b cyc %0d: got %h expected %h", c, obs_b, exp_vec(1)); end
    end
    button = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_bounce();
    test_release();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
